// File: rtl/seg_ctrl_pkg.sv
// Shared constants and types for the chaser button control stage.
// Holds the config bundle, its reset defaults and the saturating speed step.
package seg_ctrl_pkg;

    localparam int SPEED_W = 3;

    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
    localparam logic [SPEED_W-1:0] SPEED_MIN = 3'd0;

    localparam logic DIR_RESET    = 1'b1;
    localparam logic TAIL_RESET   = 1'b1;
    localparam logic INVERT_RESET = 1'b0;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic               direction;
        logic               tail;
        logic               invert;
    } cfg_t;

    // Opposing presses cancel; both ends saturate.
    function automatic logic [SPEED_W-1:0] speed_next(
        input logic [SPEED_W-1:0] cur,
        input logic               up,
        input logic               down
    );
        logic [SPEED_W-1:0] nxt;
        nxt = cur;
        if (up && !down && cur != SPEED_MAX) begin
            nxt = cur + 1'b1;
        end else if (down && !up && cur != SPEED_MIN) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, stable-count debounce,
// and a one-cycle pulse on the debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int DEBOUNCE_WIDTH  = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DEBOUNCE_WIDTH-1:0] COUNT_LAST =
        DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                      sync1;
    logic                      sync2;
    logic                      deb_q;
    logic [DEBOUNCE_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            deb_q <= 1'b0;
            count <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= level;
            // Any agreeing cycle restarts the stability window.
            if (sync2 == level) begin
                count <= '0;
            end else if (count == COUNT_LAST) begin
                level <= sync2;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign press = level & ~deb_q;

endmodule

// File: rtl/seg_ctrl_buttons.sv
// Button front end for the 7-segment chaser: five debounced buttons
// drive the registered speed/direction/tail/invert configuration.
module seg_ctrl_buttons
    import seg_ctrl_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 4096,
    parameter int                 DEBOUNCE_WIDTH  = 13,
    parameter logic [SPEED_W-1:0] SPEED_RESET     = 3'd3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_speed_up,
    input  logic               btn_speed_down,
    input  logic               btn_dir,
    input  logic               btn_tail,
    input  logic               btn_invert,
    output logic [SPEED_W-1:0] speed_level,
    output logic               direction,
    output logic               tail,
    output logic               led_invert,
    output logic               cfg_changed
);

    logic [4:0] raw;
    logic [4:0] press;
    cfg_t       cfg;
    cfg_t       cfg_nx;

    assign raw = {btn_invert, btn_tail, btn_dir,
                  btn_speed_down, btn_speed_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .level(),
            .press(press[i])
        );
    end

    always_comb begin
        cfg_nx           = cfg;
        cfg_nx.speed     = speed_next(cfg.speed, press[0], press[1]);
        cfg_nx.direction = cfg.direction ^ press[2];
        cfg_nx.tail      = cfg.tail ^ press[3];
        cfg_nx.invert    = cfg.invert ^ press[4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg.speed     <= SPEED_RESET;
            cfg.direction <= DIR_RESET;
            cfg.tail      <= TAIL_RESET;
            cfg.invert    <= INVERT_RESET;
            cfg_changed   <= 1'b0;
        end else begin
            cfg         <= cfg_nx;
            cfg_changed <= (cfg_nx != cfg);
        end
    end

    assign speed_level = cfg.speed;
    assign direction   = cfg.direction;
    assign tail        = cfg.tail;
    assign led_invert  = cfg.invert;

endmodule

// File: tb/tb_seg_ctrl_buttons.sv
// Self-checking bench for seg_ctrl_buttons with a short debounce window.
// Expected config snapshots are queued at stimulus time, popped on cfg_changed.
module tb_seg_ctrl_buttons;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_speed_up = 1'b0;
    logic       btn_speed_down = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_tail = 1'b0;
    logic       btn_invert = 1'b0;
    logic [2:0] speed_level;
    logic       direction;
    logic       tail;
    logic       led_invert;
    logic       cfg_changed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] s;
        logic       d;
        logic       t;
        logic       i;
        int         at;
    } exp_t;

    exp_t q[$];

    logic [2:0] m_s;
    logic       m_d;
    logic       m_t;
    logic       m_i;

    seg_ctrl_buttons #(
        .DEBOUNCE_CYCLES(DC),
        .DEBOUNCE_WIDTH (3),
        .SPEED_RESET    (3'd3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_speed_up  (btn_speed_up),
        .btn_speed_down(btn_speed_down),
        .btn_dir       (btn_dir),
        .btn_tail      (btn_tail),
        .btn_invert    (btn_invert),
        .speed_level   (speed_level),
        .direction     (direction),
        .tail          (tail),
        .led_invert    (led_invert),
        .cfg_changed   (cfg_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (cfg_changed === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cfg_changed cyc=%0d got spd=%0d d=%b t=%b i=%b",
                         cyc, speed_level, direction, tail, led_invert);
            end else begin
                e = q.pop_front();
                if ({speed_level, direction, tail, led_invert} !== {e.s, e.d, e.t, e.i}
                    || cyc != e.at) begin
                    errors++;
                    $display("FAIL cfg_update got spd=%0d d=%b t=%b i=%b cyc=%0d exp spd=%0d d=%b t=%b i=%b cyc=%0d",
                             speed_level, direction, tail, led_invert, cyc,
                             e.s, e.d, e.t, e.i, e.at);
                end
            end
        end
    end

    task automatic model_reset();
        m_s = 3'd3;
        m_d = 1'b1;
        m_t = 1'b1;
        m_i = 1'b0;
    endtask

    task automatic push_model(input int at);
        exp_t e;
        e.s  = m_s;
        e.d  = m_d;
        e.t  = m_t;
        e.i  = m_i;
        e.at = at;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {btn_invert, btn_tail, btn_dir, btn_speed_down, btn_speed_up} = 5'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string name);
        checks++;
        if ({speed_level, direction, tail, led_invert} !== {m_s, m_d, m_t, m_i}) begin
            errors++;
            $display("FAIL %s got spd=%0d d=%b t=%b i=%b exp spd=%0d d=%b t=%b i=%b",
                     name, speed_level, direction, tail, led_invert, m_s, m_d, m_t, m_i);
        end
    endtask

    // mask bits: invert, tail, dir, down, up
    task automatic press(input logic [4:0] mask, input string name);
        logic [2:0] ns;
        logic       changed;
        @(negedge clk);
        {btn_invert, btn_tail, btn_dir, btn_speed_down, btn_speed_up} = mask;
        ns = m_s;
        if (mask[0] && !mask[1] && m_s != 3'd7) ns = m_s + 3'd1;
        if (mask[1] && !mask[0] && m_s != 3'd0) ns = m_s - 3'd1;
        changed = (ns != m_s) || (mask[4:2] != 3'b0);
        m_s = ns;
        m_d = m_d ^ mask[2];
        m_t = m_t ^ mask[3];
        m_i = m_i ^ mask[4];
        if (changed) push_model(cyc + LAT);
        repeat (10) @(negedge clk);
        {btn_invert, btn_tail, btn_dir, btn_speed_down, btn_speed_up} = 5'b0;
        repeat (10) @(negedge clk);
        check_model(name);
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        check_model("reset_values");
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cfg_changed !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_cfg_changed got %0d high cycles exp 0", bad);
        end
        check_model("idle_values");
    endtask

    task automatic test_speed_up_latency();
        int t0;
        int bad;
        @(negedge clk);
        btn_speed_up = 1'b1;
        t0 = cyc;
        m_s = 3'd4;
        push_model(t0 + LAT);
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (speed_level !== 3'd3) begin
            errors++;
            $display("FAIL speed_early got %0d exp 3", speed_level);
        end
        @(negedge clk);
        checks++;
        if (speed_level !== 3'd4) begin
            errors++;
            $display("FAIL speed_on_time got %0d exp 4", speed_level);
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (speed_level !== 3'd4) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL speed_hold got %0d bad cycles exp 0", bad);
        end
        btn_speed_up = 1'b0;
        repeat (10) @(negedge clk);
        check_model("speed_after_release");
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            btn_dir = ~btn_dir;
            @(negedge clk);
            if (direction !== m_d) bad++;
        end
        repeat (4) begin
            @(negedge clk);
            if (direction !== m_d) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_toggle got %0d bad cycles exp 0", bad);
        end
        @(negedge clk);
        btn_dir = 1'b1;
        m_d = ~m_d;
        push_model(cyc + LAT);
        repeat (20) @(negedge clk);
        btn_dir = 1'b0;
        repeat (10) @(negedge clk);
        check_model("dir_after_bounce");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) press(5'b00001, "speed_up_sat");
        checks++;
        if (speed_level !== 3'd7) begin
            errors++;
            $display("FAIL speed_max got %0d exp 7", speed_level);
        end
        for (int k = 0; k < 8; k++) press(5'b00010, "speed_down_sat");
        checks++;
        if (speed_level !== 3'd0) begin
            errors++;
            $display("FAIL speed_min got %0d exp 0", speed_level);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(5'b01011, "up_down_tail");
        press(5'b10100, "dir_invert");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        btn_invert = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_model("mid_reset_values");
        reset = 1'b0;
        m_i = 1'b1;
        push_model(cyc + LAT);
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (led_invert !== 1'b0) begin
            errors++;
            $display("FAIL invert_early got %b exp 0", led_invert);
        end
        @(negedge clk);
        checks++;
        if (led_invert !== 1'b1) begin
            errors++;
            $display("FAIL invert_on_time got %b exp 1", led_invert);
        end
        repeat (5) @(negedge clk);
        btn_invert = 1'b0;
        repeat (10) @(negedge clk);
        check_model("invert_after_release");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_speed_up_latency();
        test_bounce();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_cfg_changed got %0d pending exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
